// File: rtl/ibuf_pin_conditioner.sv
// ibuf_pin_conditioner: synchronise, debounce and edge-detect asynchronous board pins.
// Optional sticky edge flags on evt_o when PIN_COND_EVT_LATCH_EN is defined.
module ibuf_pin_conditioner #(
  parameter int                WIDTH          = 4,
  parameter int                SYNC_STAGES    = 2,
  parameter int                DEBOUNCE_TICKS = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL      = '0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] pin_i,
  input  logic             tick_i,
  output logic [WIDTH-1:0] pin_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] evt_o,
  input  logic [WIDTH-1:0] evt_clr_i
);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] pin_q, pin_d, rise_q, fall_q;
  logic             unused;
  assign unused = &{1'b0, tick_i, evt_clr_i};
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VAL;
    end else begin
      sync_q[0] <= pin_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  assign sync = sync_q[SYNC_STAGES-1];
  generate
    if (DEBOUNCE_TICKS == 0) begin : g_bypass
      always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) pin_q <= RESET_VAL;
        else         pin_q <= sync;
    end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt_q;
        logic          stable_q;
        // a disagreeing level must survive DEBOUNCE_TICKS ticks in a row; any agreement restarts it
        always_ff @(posedge clk_i or negedge rstn_i)
          if (!rstn_i) begin
            cnt_q    <= '0;
            stable_q <= RESET_VAL[i];
          end else if (sync[i] == stable_q) begin
            cnt_q <= '0;
          end else if (tick_i) begin
            if (cnt_q == LAST) begin
              stable_q <= sync[i];
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        assign pin_q[i] = stable_q;
      end
    end
  endgenerate
  // pin_d resets with pin_q so neither reset nor release produces a pulse
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      pin_d  <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      pin_d  <= pin_q;
      rise_q <= pin_q & ~pin_d;
      fall_q <= ~pin_q & pin_d;
    end
  assign pin_o  = pin_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`ifdef PIN_COND_EVT_LATCH_EN
  logic [WIDTH-1:0] evt_q;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) evt_q <= '0;
    else         evt_q <= (evt_q & ~evt_clr_i) | rise_q | fall_q;
  assign evt_o = evt_q;
`else
  assign evt_o = '0;
`endif
endmodule
